// File: rtl/motor_ctrl_pkg.sv
// Shared definitions for the motor shutdown controller and its neighbours:
// controller state encoding, default timing constants and a duty ramp helper.
package motor_ctrl_pkg;

    // Controller states
    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StRun      = 3'd1,
        StRampDn   = 3'd2,
        StHalt     = 3'd3,
        StCooldown = 3'd4,
        StLockout  = 3'd5
    } state_e;

    // Default constants, in clk_1khz cycles where they are times
    localparam int unsigned DefTripFilt = 2;
    localparam int unsigned DefStep     = 5;
    localparam int unsigned DefCooldown = 250;
    localparam int unsigned DefMaxRetry = 3;
    localparam int unsigned DefStable   = 1000;

    localparam logic [7:0] DutyMax = 8'd255;

    // Saturating duty decrement: never wraps below zero
    function automatic logic [7:0] duty_step_down(input logic [7:0] duty,
                                                  input logic [7:0] step);
        return (duty > step) ? (duty - step) : 8'd0;
    endfunction

endpackage

// File: rtl/trip_filter.sv
// Consecutive-cycle qualifier for the watchdog trip request. trip_ok is high
// in the cycle where the input has been high for C_TRIP_FILT cycles in a row
// (including the current one); the count saturates and any low cycle clears it.
module trip_filter
    import motor_ctrl_pkg::*;
#(
    parameter int unsigned C_TRIP_FILT = DefTripFilt
) (
    input  logic clk_1khz,
    input  logic rst,
    input  logic trip_in,
    output logic trip_ok
);

    localparam int unsigned CntW = (C_TRIP_FILT < 2) ? 1 : $clog2(C_TRIP_FILT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(C_TRIP_FILT);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Next count: clear on a low cycle, otherwise count up and hold at the limit
    always_comb begin
        cnt_d = '0;
        if (trip_in) begin
            cnt_d = (cnt_q == CntMax) ? cnt_q : (cnt_q + CntW'(1));
        end
        trip_ok = trip_in && (cnt_d == CntMax);
    end

    // Count register with synchronous reset
    always_ff @(posedge clk_1khz) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/motor_shutdown_ctrl.sv
// Motor shutdown controller: runs the motor on request, ramps the duty down on
// a qualified watchdog trip or a dropped request, halts and cools down after a
// trip, and locks out after too many trips until an operator clear.
// All outputs are registered from the current state, so they trail the state
// register by one cycle.
module motor_shutdown_ctrl
    import motor_ctrl_pkg::*;
#(
    parameter int unsigned C_TRIP_FILT = DefTripFilt,
    parameter int unsigned C_STEP      = DefStep,
    parameter int unsigned C_COOLDOWN  = DefCooldown,  // must be >= 1
    parameter int unsigned C_MAX_RETRY = DefMaxRetry,
    parameter int unsigned C_STABLE    = DefStable     // must be >= 1
) (
    input  logic       clk_1khz,
    input  logic       rst,
    input  logic       wd_trip,
    input  logic       motor_en_req,
    input  logic       clr_fault,
    output logic       motor_en,
    output logic       brake_on,
    output logic [7:0] duty,
    output logic       fault_latched,
    output logic [1:0] retry_cnt,
    output logic       lockout
);

    localparam int unsigned CdW = (C_COOLDOWN < 2) ? 1 : $clog2(C_COOLDOWN + 1);
    localparam int unsigned StW = (C_STABLE < 2) ? 1 : $clog2(C_STABLE + 1);
    localparam logic [CdW-1:0] CdLast = CdW'(C_COOLDOWN - 1);
    localparam logic [StW-1:0] StMax  = StW'(C_STABLE);
    localparam logic [7:0]     StepW  = 8'(C_STEP);

    state_e         state_q, state_d;
    logic [7:0]     ramp_q, ramp_d;
    logic           trip_flag_q, trip_flag_d;
    logic [CdW-1:0] cd_q, cd_d;
    logic [StW-1:0] stable_q, stable_d;
    logic           fault_q, fault_d;
    logic [1:0]     retry_q, retry_d;
    logic [1:0]     retry_inc;

    logic           filt_in;
    logic           filt_trip;

    logic           motor_en_q, motor_en_d;
    logic           brake_on_q, brake_on_d;
    logic [7:0]     duty_q, duty_d;
    logic           fault_out_q;
    logic [1:0]     retry_out_q;
    logic           lockout_q, lockout_d;

    // Trips only count while running, so the filter sees a gated request
    assign filt_in = wd_trip && (state_q == StRun);

    trip_filter #(
        .C_TRIP_FILT (C_TRIP_FILT)
    ) u_trip_filter (
        .clk_1khz (clk_1khz),
        .rst      (rst),
        .trip_in  (filt_in),
        .trip_ok  (filt_trip)
    );

    assign retry_inc = (retry_q == 2'd3) ? 2'd3 : (retry_q + 2'd1);

    // Next-state logic and bookkeeping counters
    always_comb begin
        state_d     = state_q;
        ramp_d      = ramp_q;
        trip_flag_d = trip_flag_q;
        cd_d        = cd_q;
        stable_d    = '0;
        fault_d     = fault_q;
        retry_d     = retry_q;

        case (state_q)
            StIdle: begin
                if (clr_fault) begin
                    fault_d = 1'b0;
                end
                if (motor_en_req && !wd_trip) begin
                    state_d = StRun;
                end
            end

            StRun: begin
                stable_d = (stable_q == StMax) ? stable_q : (stable_q + StW'(1));
                if (stable_d == StMax) begin
                    retry_d = 2'd0;
                end
                // Trip path wins over a simultaneous request drop
                if (filt_trip) begin
                    state_d     = StRampDn;
                    trip_flag_d = 1'b1;
                    ramp_d      = duty_step_down(DutyMax, StepW);
                end else if (!motor_en_req) begin
                    state_d     = StRampDn;
                    trip_flag_d = 1'b0;
                    ramp_d      = duty_step_down(DutyMax, StepW);
                end
            end

            StRampDn: begin
                if (ramp_q == 8'd0) begin
                    if (trip_flag_q) begin
                        state_d = StHalt;
                        fault_d = 1'b1;
                        retry_d = retry_inc;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    ramp_d = duty_step_down(ramp_q, StepW);
                end
            end

            StHalt: begin
                // retry_q already holds the post-increment count here
                if (32'(retry_q) >= C_MAX_RETRY) begin
                    state_d = StLockout;
                end else begin
                    state_d = StCooldown;
                    cd_d    = '0;
                end
            end

            StCooldown: begin
                if (cd_q == CdLast) begin
                    cd_d = '0;
                    if (!wd_trip) begin
                        state_d = StIdle;
                    end
                end else begin
                    cd_d = cd_q + CdW'(1);
                end
            end

            StLockout: begin
                if (clr_fault && !wd_trip) begin
                    state_d = StIdle;
                    retry_d = 2'd0;
                    fault_d = 1'b0;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Moore output decode from the current state
    always_comb begin
        motor_en_d = 1'b0;
        brake_on_d = 1'b1;
        duty_d     = 8'd0;
        lockout_d  = 1'b0;
        case (state_q)
            StRun: begin
                motor_en_d = 1'b1;
                brake_on_d = 1'b0;
                duty_d     = DutyMax;
            end
            StRampDn: begin
                motor_en_d = 1'b1;
                brake_on_d = 1'b0;
                duty_d     = ramp_q;
            end
            StLockout: begin
                lockout_d = 1'b1;
            end
            default: begin
                motor_en_d = 1'b0;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk_1khz) begin
        if (rst) begin
            state_q     <= StIdle;
            ramp_q      <= 8'd0;
            trip_flag_q <= 1'b0;
            cd_q        <= '0;
            stable_q    <= '0;
            fault_q     <= 1'b0;
            retry_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            ramp_q      <= ramp_d;
            trip_flag_q <= trip_flag_d;
            cd_q        <= cd_d;
            stable_q    <= stable_d;
            fault_q     <= fault_d;
            retry_q     <= retry_d;
        end
    end

    // Output registers
    always_ff @(posedge clk_1khz) begin
        if (rst) begin
            motor_en_q  <= 1'b0;
            brake_on_q  <= 1'b1;
            duty_q      <= 8'd0;
            fault_out_q <= 1'b0;
            retry_out_q <= 2'd0;
            lockout_q   <= 1'b0;
        end else begin
            motor_en_q  <= motor_en_d;
            brake_on_q  <= brake_on_d;
            duty_q      <= duty_d;
            fault_out_q <= fault_q;
            retry_out_q <= retry_q;
            lockout_q   <= lockout_d;
        end
    end

    assign motor_en      = motor_en_q;
    assign brake_on      = brake_on_q;
    assign duty          = duty_q;
    assign fault_latched = fault_out_q;
    assign retry_cnt     = retry_out_q;
    assign lockout       = lockout_q;

endmodule

// File: tb/tb_motor_shutdown_ctrl.sv
// Bench for motor_shutdown_ctrl: directed scenarios followed by a random soak,
// every cycle compared against a behavioural model of the controller.
module tb_motor_shutdown_ctrl;
    import motor_ctrl_pkg::*;

    localparam int MIdle = 0, MRun = 1, MRamp = 2, MHalt = 3, MCool = 4, MLock = 5;

    logic       clk_1khz = 1'b0;
    logic       rst, wd_trip, motor_en_req, clr_fault;
    logic       motor_en, brake_on, fault_latched, lockout;
    logic [7:0] duty;
    logic [1:0] retry_cnt;

    always #5 clk_1khz = ~clk_1khz;

    motor_shutdown_ctrl dut (
        .clk_1khz      (clk_1khz),
        .rst           (rst),
        .wd_trip       (wd_trip),
        .motor_en_req  (motor_en_req),
        .clr_fault     (clr_fault),
        .motor_en      (motor_en),
        .brake_on      (brake_on),
        .duty          (duty),
        .fault_latched (fault_latched),
        .retry_cnt     (retry_cnt),
        .lockout       (lockout)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model state: mode, ramp level, trip origin, timers, sticky flags
    int m_mode = MIdle, m_ramp = 0, m_flag = 0, m_cd = 0, m_stable = 0, m_tcnt = 0;
    int m_fault = 0, m_retry = 0;
    logic [13:0] exp_vec = {1'b0, 1'b1, 8'd0, 1'b0, 2'd0, 1'b0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Advance the model by one clock edge; expected outputs reflect the
    // behaviour held before the edge, since outputs are registered.
    task automatic model_step(input bit r, input bit t, input bit q, input bit c);
        int nxt;
        logic       e_en;
        logic [7:0] e_duty;
        if (r) begin
            m_mode = MIdle; m_ramp = 0; m_flag = 0; m_cd = 0; m_stable = 0; m_tcnt = 0;
            m_fault = 0; m_retry = 0;
            exp_vec = {1'b0, 1'b1, 8'd0, 1'b0, 2'd0, 1'b0};
            return;
        end
        e_en   = (m_mode == MRun) || (m_mode == MRamp);
        e_duty = (m_mode == MRun) ? 8'd255 : (m_mode == MRamp) ? 8'(m_ramp) : 8'd0;
        exp_vec = {e_en, !e_en, e_duty, m_fault[0], 2'(m_retry), (m_mode == MLock)};

        nxt = m_mode;
        if (m_mode != MRun) begin
            m_tcnt = 0;
            m_stable = 0;
        end
        case (m_mode)
            MIdle: begin
                if (c) m_fault = 0;
                if (q && !t) nxt = MRun;
            end
            MRun: begin
                m_tcnt = t ? ((m_tcnt + 1 > DefTripFilt) ? DefTripFilt : m_tcnt + 1) : 0;
                m_stable = (m_stable + 1 > DefStable) ? DefStable : m_stable + 1;
                if (m_stable == DefStable) m_retry = 0;
                if (m_tcnt == DefTripFilt || !q) begin
                    nxt = MRamp;
                    m_flag = (m_tcnt == DefTripFilt);
                    m_ramp = (255 > DefStep) ? 255 - DefStep : 0;
                end
            end
            MRamp: begin
                if (m_ramp == 0) begin
                    if (m_flag != 0) begin
                        nxt = MHalt;
                        m_fault = 1;
                        m_retry = (m_retry < 3) ? m_retry + 1 : 3;
                    end else begin
                        nxt = MIdle;
                    end
                end else begin
                    m_ramp = (m_ramp > DefStep) ? m_ramp - DefStep : 0;
                end
            end
            MHalt: begin
                nxt = (m_retry >= DefMaxRetry) ? MLock : MCool;
                m_cd = 0;
            end
            MCool: begin
                m_cd++;
                if (m_cd == DefCooldown) begin
                    m_cd = 0;
                    if (!t) nxt = MIdle;
                end
            end
            default: begin
                if (c && !t) begin
                    nxt = MIdle;
                    m_retry = 0;
                    m_fault = 0;
                end
            end
        endcase
        m_mode = nxt;
    endtask

    task automatic tick(input bit r, input bit t, input bit q, input bit c);
        logic [13:0] obs;
        rst = r; wd_trip = t; motor_en_req = q; clr_fault = c;
        @(posedge clk_1khz);
        model_step(r, t, q, c);
        #1;
        cyc++;
        obs = {motor_en, brake_on, duty, fault_latched, retry_cnt, lockout};
        check($sformatf("cycle%0d", cyc), 32'(obs), 32'(exp_vec));
    endtask

    task automatic ticks(input int n, input bit t, input bit q, input bit c);
        repeat (n) tick(1'b0, t, q, c);
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Enter RUN, qualify a trip, then let the ramp and HALT play out
    task automatic do_trip();
        ticks(3, 1'b0, 1'b1, 1'b0);
        ticks(2, 1'b1, 1'b1, 1'b0);
        ticks(60, 1'b0, 1'b0, 1'b0);
    endtask

    // Tick with fixed inputs until motor_en drops; bounded
    task automatic wait_stop(input bit q, output bit done, output int ramp_cnt);
        done = 1'b0;
        ramp_cnt = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            tick(1'b0, 1'b0, q, 1'b0);
            if (!motor_en) done = 1'b1;
            else if (duty != 8'd255) ramp_cnt++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        bit done;
        int n;
        bit r, t, q, c;
        int trip_left;

        // Reset and a single-cycle trip glitch, then a qualified trip
        do_reset();
        check("rst_vec", 32'({motor_en, brake_on, duty, fault_latched, retry_cnt, lockout}),
              32'({1'b0, 1'b1, 8'd0, 1'b0, 2'd0, 1'b0}));
        ticks(3, 1'b0, 1'b1, 1'b0);
        check("run_duty", 32'(duty), 32'd255);
        check("run_en", 32'(motor_en), 32'd1);
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        ticks(5, 1'b0, 1'b1, 1'b0);
        check("glitch_no_trip", 32'(duty), 32'd255);
        ticks(2, 1'b1, 1'b1, 1'b0);
        wait_stop(1'b1, done, n);
        check("trip_stop_seen", 32'(done), 32'd1);
        check("ramp_cycles", 32'(n), 32'd51);
        check("halt_fault", 32'(fault_latched), 32'd1);
        check("halt_retry", 32'(retry_cnt), 32'd1);
        check("halt_brake", 32'(brake_on), 32'd1);
        ticks(255, 1'b0, 1'b0, 1'b0);
        check("cool_fault_kept", 32'(fault_latched), 32'd1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check("idle_clr_fault", 32'(fault_latched), 32'd0);
        check("idle_clr_retry", 32'(retry_cnt), 32'd1);

        // Request drop: ramp to zero without a fault
        ticks(3, 1'b0, 1'b1, 1'b0);
        wait_stop(1'b0, done, n);
        check("drop_stop_seen", 32'(done), 32'd1);
        check("drop_ramp_cycles", 32'(n), 32'd51);
        check("drop_fault", 32'(fault_latched), 32'd0);
        check("drop_retry", 32'(retry_cnt), 32'd1);

        // Three trips -> lockout; clear only honoured with wd_trip low
        do_reset();
        do_trip();
        check("trip1_retry", 32'(retry_cnt), 32'd1);
        ticks(255, 1'b0, 1'b0, 1'b0);
        do_trip();
        check("trip2_retry", 32'(retry_cnt), 32'd2);
        ticks(255, 1'b0, 1'b0, 1'b0);
        do_trip();
        check("trip3_retry", 32'(retry_cnt), 32'd3);
        check("trip3_lockout", 32'(lockout), 32'd1);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        ticks(3, 1'b1, 1'b0, 1'b0);
        check("lock_clr_ignored", 32'(lockout), 32'd1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        ticks(2, 1'b0, 1'b0, 1'b0);
        check("lock_clr_lockout", 32'(lockout), 32'd0);
        check("lock_clr_retry", 32'(retry_cnt), 32'd0);
        check("lock_clr_fault", 32'(fault_latched), 32'd0);

        // Trip held across cooldown end restarts it. Cooldown ends 242 cycles
        // after do_trip; holding 250 cycles leaves 242 of the restarted period,
        // plus IDLE->RUN and the output register: motor_en after 244 ticks.
        do_reset();
        do_trip();
        ticks(250, 1'b1, 1'b0, 1'b0);
        done = 1'b0;
        n = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            tick(1'b0, 1'b0, 1'b1, 1'b0);
            n++;
            if (motor_en) done = 1'b1;
        end
        check("cool_restart_seen", 32'(done), 32'd1);
        check("cool_restart_len", 32'(n), 32'd244);

        // Reset mid-ramp at duty 130
        do_reset();
        ticks(3, 1'b0, 1'b1, 1'b0);
        ticks(2, 1'b1, 1'b1, 1'b0);
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            tick(1'b0, 1'b0, 1'b1, 1'b0);
            if (duty == 8'd130) done = 1'b1;
        end
        check("duty130_seen", 32'(done), 32'd1);
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        check("mid_ramp_rst", 32'({motor_en, brake_on, duty, fault_latched, retry_cnt, lockout}),
              32'({1'b0, 1'b1, 8'd0, 1'b0, 2'd0, 1'b0}));

        // Two trips, long stable run clears retries; simultaneous trip and drop
        do_reset();
        do_trip();
        ticks(255, 1'b0, 1'b0, 1'b0);
        do_trip();
        ticks(255, 1'b0, 1'b0, 1'b0);
        check("pre_stable_retry", 32'(retry_cnt), 32'd2);
        ticks(1005, 1'b0, 1'b1, 1'b0);
        check("stable_retry", 32'(retry_cnt), 32'd0);
        check("stable_en", 32'(motor_en), 32'd1);
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        wait_stop(1'b0, done, n);
        check("both_stop_seen", 32'(done), 32'd1);
        check("both_fault", 32'(fault_latched), 32'd1);
        check("both_retry", 32'(retry_cnt), 32'd1);

        // Random soak against the model
        do_reset();
        trip_left = 0;
        q = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(0, 599) == 0);
            if (trip_left > 0) trip_left--;
            else if ($urandom_range(0, 59) == 0)
                trip_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(200, 400))
                                                        : int'($urandom_range(1, 3));
            t = (trip_left > 0);
            if ($urandom_range(0, 99) == 0) q = !q;
            c = ($urandom_range(0, 39) == 0);
            tick(r, t, q, c);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/motor_shutdown_ctrl.md
MOTOR_SHUTDOWN_CTRL -- requirements
Module: motor_shutdown_ctrl

Interface
REQ-001 C_TRIP_FILT, default 2: consecutive cycles wd_trip must be high before a trip is accepted.
REQ-002 C_STEP, default 5: duty decrement per cycle during ramp-down.
REQ-003 C_COOLDOWN, default 250: cooldown length in clk_1khz cycles.
REQ-004 C_MAX_RETRY, default 3: trips tolerated before lockout.
REQ-005 C_STABLE, default 1000: continuous RUN cycles that clear retry_cnt.
REQ-006 clk_1khz  in  1  system 1 kHz clock; all logic on its rising edge.
REQ-007 rst  in  1  reset, synchronous and active-high.
REQ-008 wd_trip  in  1  shutdown request from the upstream watchdog timer output, synchronous to clk_1khz.
REQ-009 motor_en_req  in  1  level run request from system control.
REQ-010 clr_fault  in  1  single-cycle operator fault clear.
REQ-011 motor_en  out  1  motor driver enable.
REQ-012 brake_on  out  1  mechanical brake engage.
REQ-013 duty  out  8  drive duty command, 0 to 255.
REQ-014 fault_latched  out  1  sticky trip indication.
REQ-015 retry_cnt  out  2  trips since last stable run or clear.
REQ-016 lockout  out  1  high while in LOCKOUT.

Function
REQ-017 Outputs SHALL be registered Moore outputs, valid the cycle after the state register updates.
REQ-018 States SHALL be IDLE, RUN, RAMP_DN, HALT, COOLDOWN, LOCKOUT.
REQ-019 IDLE: motor_en=0, brake_on=1, duty=0; motor_en_req=1 and wd_trip=0 -> RUN next cycle.
REQ-020 RUN: motor_en=1, brake_on=0, duty=255.
REQ-021 Trip filter counter SHALL count consecutive wd_trip-high cycles in RUN, reset to 0 on any low cycle, and saturate at C_TRIP_FILT.
REQ-022 In RUN, filter reaching C_TRIP_FILT -> RAMP_DN with trip flag set; motor_en_req=0 -> RAMP_DN with trip flag clear.
REQ-023 If both conditions occur in the same cycle, the trip path SHALL win.
REQ-024 RAMP_DN: motor_en=1, brake_on=0; duty SHALL decrease by C_STEP per cycle, saturating at 0 with no wrap-around.
REQ-025 When duty reaches 0, a set trip flag -> HALT; a clear trip flag -> IDLE.
REQ-026 HALT SHALL last one cycle: motor_en=0, brake_on=1, fault_latched set, retry_cnt incremented (saturating at 3).
REQ-027 After HALT, post-increment retry_cnt >= C_MAX_RETRY -> LOCKOUT; otherwise -> COOLDOWN.
REQ-028 COOLDOWN: motor_en=0, brake_on=1; after C_COOLDOWN cycles, wd_trip=0 -> IDLE; wd_trip=1 -> counter restarts.
REQ-029 LOCKOUT: motor_en=0, brake_on=1, lockout=1; clr_fault=1 with wd_trip=0 -> IDLE, retry_cnt=0, fault_latched=0.
REQ-030 clr_fault in IDLE SHALL clear fault_latched only; in other states it SHALL be ignored.
REQ-031 C_STABLE consecutive RUN cycles SHALL clear retry_cnt; leaving RUN resets the stable counter.
REQ-032 wd_trip during RAMP_DN, HALT or COOLDOWN SHALL NOT re-enter RAMP_DN or double-count retries.

Reset
REQ-033 rst=1 SHALL force state=IDLE, motor_en=0, brake_on=1, duty=0, fault_latched=0, retry_cnt=0, lockout=0, and clear all counters on the next edge, including mid-ramp or mid-cooldown.
REQ-034 Reset SHALL take priority over every other input.

Structure
REQ-035 State encoding and the C_* default constants SHALL live in a shared package, motor_ctrl_pkg, for reuse by the watchdog and benches.
REQ-036 The trip filter SHALL be a sub-module, trip_filter, with clk_1khz, rst, an input and a C_TRIP_FILT parameter; everything else SHALL stay in one FSM module.

Verification
REQ-037 Request run, hold wd_trip=1 for 1 cycle -> no trip; hold 2 cycles -> RAMP_DN, duty 255,250,...,5,0 over 51 cycles, then HALT, fault_latched=1, retry_cnt=1.
REQ-038 Drop motor_en_req in RUN -> ramp to 0, then IDLE, fault_latched=0, retry_cnt unchanged.
REQ-039 Three trips with cooldowns between -> third HALT enters LOCKOUT; clr_fault with wd_trip=1 is ignored; clr_fault with wd_trip=0 -> IDLE, retry_cnt=0.
REQ-040 Hold wd_trip=1 through cooldown end -> cooldown restarts; release -> IDLE after 250 further cycles.
REQ-041 Assert rst at duty=130 -> next cycle IDLE, duty=0, brake_on=1, all flags 0.
REQ-042 Two trips, then 1000 stable RUN cycles -> retry_cnt=0; trip-filter expiry and req drop in the same cycle -> HALT path taken.
